// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle: PC/prediction towards the predictor and instruction buffer,
// plus execute-stage branch resolution coming back.
interface fetch_pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] PC;
    logic            predict_taken;
    logic            fetch_valid;
    logic            fetch_ready;
    logic            fetch_pred_taken;
    logic [XLEN-1:0] fetch_pred_target;
    logic            ex_branch;
    logic [XLEN-1:0] ex_PC;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_mispredict;

    modport master (
        output PC, fetch_valid, fetch_pred_taken, fetch_pred_target,
        input  predict_taken, fetch_ready, ex_branch, ex_PC, ex_taken, ex_target, ex_mispredict
    );

    modport slave (
        input  PC, fetch_valid, fetch_pred_taken, fetch_pred_target,
        output predict_taken, fetch_ready, ex_branch, ex_PC, ex_taken, ex_target, ex_mispredict
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: holds the fetch PC, predicts taken branches through a direct-mapped BTB
// (built only when FETCH_BTB_EN is defined) and redirects on execute-stage mispredicts.
module fetch_pc_unit #(
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input logic             clock,
    input logic             reset,
    fetch_pc_unit_if.master bus
);
    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid;
    logic            transfer;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    assign fetch_valid = (state_q == StRun);
    assign transfer    = fetch_valid & bus.fetch_ready;

`ifdef FETCH_BTB_EN
    localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW = XLEN - IdxW - 2;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TagW-1:0]        btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
    logic [IdxW-1:0]        rd_idx, wr_idx;
    logic                   btb_hit;
    logic                   btb_write;

    assign rd_idx      = pc_q[IdxW+1:2];
    assign wr_idx      = bus.ex_PC[IdxW+1:2];
    assign btb_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[XLEN-1:IdxW+2]);
    assign btb_write   = bus.ex_branch & bus.ex_taken;
    assign pred_taken  = fetch_valid & btb_hit & bus.predict_taken;
    assign pred_target = pred_taken ? btb_target_q[rd_idx] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btb_valid_q <= '0;
        end else if (btb_write) begin
            btb_valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target are only observed behind a valid bit, so they carry no reset.
    always_ff @(posedge clock) begin
        if (btb_write) begin
            btb_tag_q[wr_idx]    <= bus.ex_PC[XLEN-1:IdxW+2];
            btb_target_q[wr_idx] <= bus.ex_target;
        end
    end
`else
    logic unused_btb_inputs;
    assign unused_btb_inputs = bus.predict_taken ^ bus.ex_branch;
    assign pred_taken        = 1'b0;
    assign pred_target       = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.ex_mispredict) begin
            pc_d    = bus.ex_taken ? bus.ex_target : bus.ex_PC + XLEN'(4);
            state_d = StFlush;
        end else if (state_q == StRun) begin
            if (transfer) begin
                pc_d = pred_taken ? pred_target : pc_q + XLEN'(4);
            end
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.PC                = pc_q;
    assign bus.fetch_valid       = fetch_valid;
    assign bus.fetch_pred_taken  = pred_taken;
    assign bus.fetch_pred_target = pred_target;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, hand-written reset corner cases,
// then randomized traffic checked against a behavioural model.
module tb_fetch_pc_unit;
`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif
    localparam int unsigned NENT = 16;

    typedef struct {
        bit          rdy;
        bit          pt_in;
        bit          br;
        bit          tk;
        bit          mis;
        logic [31:0] ex_pc;
        logic [31:0] ex_tgt;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_pt;
        logic [31:0] e_tgt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fetch_pc_unit_if #(.XLEN(32)) bus ();

    fetch_pc_unit #(
        .BTB_ENTRIES(NENT),
        .XLEN       (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model: a bubble flag, the PC and a map from index to last taken branch.
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_has [NENT];
    logic [31:0] m_bpc [NENT];
    logic [31:0] m_btgt [NENT];

    function automatic vec_t mk(bit rdy, bit pt_in, bit br, bit tk, bit mis, logic [31:0] ex_pc,
                                logic [31:0] ex_tgt, bit e_valid, logic [31:0] e_pc, bit e_pt,
                                logic [31:0] e_tgt);
        vec_t v;
        v.rdy = rdy; v.pt_in = pt_in; v.br = br; v.tk = tk; v.mis = mis;
        v.ex_pc = ex_pc; v.ex_tgt = ex_tgt;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_pt = e_pt; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.fetch_ready   = v.rdy;
        bus.predict_taken = v.pt_in;
        bus.ex_branch     = v.br;
        bus.ex_taken      = v.tk;
        bus.ex_mispredict = v.mis;
        bus.ex_PC         = v.ex_pc;
        bus.ex_target     = v.ex_tgt;
    endtask

    task automatic check_outs(input string tag, input bit e_valid, input logic [31:0] e_pc,
                              input bit e_pt, input logic [31:0] e_tgt);
        check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(e_valid));
        check({tag, ".pc"}, bus.PC, e_pc);
        check({tag, ".pred"}, 32'(bus.fetch_pred_taken), 32'(e_pt));
        check({tag, ".tgt"}, bus.fetch_pred_target, e_tgt);
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 2 units later.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        #2;
        check_outs(tag, v.e_valid, v.e_pc, v.e_pt, v.e_tgt);
        @(posedge clock);
        #1;
    endtask

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % NENT);
    endfunction

    function automatic bit m_hit();
        int i = idx_of(m_pc);
        return BTB_ON && m_has[i] && ((m_bpc[i] >> 2) == (m_pc >> 2));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = 32'h0;
        for (int i = 0; i < int'(NENT); i++) m_has[i] = 1'b0;
    endtask

    task automatic model_step();
        bit          pred;
        logic [31:0] tgt;
        pred = m_valid && m_hit() && bus.predict_taken;
        tgt  = m_btgt[idx_of(m_pc)];
        if (bus.ex_mispredict) begin
            m_pc    = bus.ex_taken ? bus.ex_target : bus.ex_PC + 32'd4;
            m_valid = 1'b0;
        end else begin
            if (m_valid && bus.fetch_ready) m_pc = pred ? tgt : m_pc + 32'd4;
            m_valid = 1'b1;
        end
        if (bus.ex_branch && bus.ex_taken) begin
            m_has[idx_of(bus.ex_PC)]  = 1'b1;
            m_bpc[idx_of(bus.ex_PC)]  = bus.ex_PC;
            m_btgt[idx_of(bus.ex_PC)] = bus.ex_target;
        end
    endtask

    vec_t tbl[$];
    vec_t post[$];

    initial begin
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);

        //              rdy pt br tk mis ex_pc        ex_tgt       val pc           pt tgt
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       0, 32'h0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h4,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h8,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h8,       0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h8,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h8,       0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 32'h10,      32'h40,      1, 32'hC,       0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,       32'h0,       1, 32'h10, BTB_ON,
                         BTB_ON ? 32'h40 : 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1,
                         BTB_ON ? 32'h40 : 32'h14, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h44,      32'h10,      1,
                         BTB_ON ? 32'h44 : 32'h18, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       0, 32'h10,      0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'h10,      0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 32'h50,      32'h80,      1, 32'h14,      0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'h18,      32'h10,      1, 32'h18,      0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h8,       32'h0,       0, 32'h10,      0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       0, 32'hC,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       1, 32'hC,       0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,       32'h0,       1, 32'h10,      0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'h14,      32'hFFFFFFFC, 1, 32'h14,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,       32'h0,       0, 32'hFFFFFFFC, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,       32'h0,       1, 32'hFFFFFFFC, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10,      32'h0,       1, 32'h0,       0, 0));

        // After reset: same-cycle train/lookup sees the old (cleared) entry, then hits.
        post.push_back(mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0));
        post.push_back(mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  1, 32'h0,  0, 0));
        post.push_back(mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  1, 32'h4,  0, 0));
        post.push_back(mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  1, 32'h8,  0, 0));
        post.push_back(mk(1, 0, 0, 0, 0, 32'h0,  32'h0,  1, 32'hC,  0, 0));
        post.push_back(mk(1, 1, 1, 1, 0, 32'h10, 32'h40, 1, 32'h10, 0, 0));
        post.push_back(mk(1, 0, 0, 1, 1, 32'h14, 32'h10, 1, 32'h14, 0, 0));
        post.push_back(mk(1, 1, 0, 0, 0, 32'h0,  32'h0,  0, 32'h10, 0, 0));
        post.push_back(mk(1, 1, 0, 0, 0, 32'h0,  32'h0,  1, 32'h10, BTB_ON,
                          BTB_ON ? 32'h40 : 32'h0));

        // Reset held across edges.
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset_hold", 0, 32'h0, 0, 32'h0);
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

        // Last row stalled and mispredicted: one bubble at PC+4 of ex_PC.
        drive(z);
        #2;
        check_outs("stall_mis", 0, 32'h14, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("reset_mid_flush", 0, 32'h0, 0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        foreach (post[i]) run_vec(post[i], $sformatf("post%0d", i));

        // Randomized traffic against the model, starting from a fresh reset.
        drive(z);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            vec_t r;
            bit   pred;
            r = z;
            r.rdy    = ($urandom_range(0, 3) != 0);
            r.pt_in  = $urandom_range(0, 1) == 1;
            r.br     = ($urandom_range(0, 2) == 0);
            r.tk     = $urandom_range(0, 1) == 1;
            r.mis    = ($urandom_range(0, 7) == 0);
            r.ex_pc  = 32'($urandom_range(0, 31)) << 2;
            r.ex_tgt = 32'($urandom_range(0, 63)) << 2;
            drive(r);
            #2;
            pred = m_valid && m_hit() && r.pt_in;
            check_outs($sformatf("rnd%0d", n), m_valid, m_pc, pred,
                       pred ? m_btgt[idx_of(m_pc)] : 32'h0);
            @(posedge clock);
            model_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch PC generator that sits directly upstream of `branch_prediction_unit`. It holds the fetch PC and drives it to the predictor. It combines the predictor's combinational `predict_taken` with a small direct-mapped branch target buffer (BTB) to choose the next PC. It hands each fetched PC to the instruction buffer over a valid/ready handshake and redirects on execute-stage mispredicts.

## Interface
Parameters:
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, at least 2.
- `RESET_PC`, 0: first PC fetched after reset.

Ports:
- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PC`  out  `XLEN`  current fetch PC; drives `branch_prediction_unit.PC`.
- `predict_taken`  in  1  combinational prediction for `PC` from the predictor.
- `fetch_valid`  out  1  `PC` is a valid fetch this cycle.
- `fetch_ready`  in  1  downstream accepts; a transfer occurs when `fetch_valid && fetch_ready`.
- `fetch_pred_taken`  out  1  prediction attached to the fetched instruction.
- `fetch_pred_target`  out  `XLEN`  predicted target; 0 when not predicted taken.
- `ex_branch`  in  1  execute stage resolved a branch this cycle.
- `ex_PC`  in  `XLEN`  PC of the resolved branch.
- `ex_taken`  in  1  resolved direction.
- `ex_target`  in  `XLEN`  resolved taken target.
- `ex_mispredict`  in  1  resolved outcome differs from the prediction; forces a redirect.

## Operation
- BTB is direct-mapped.
  - Index = `PC[log2(BTB_ENTRIES)+1:2]`; tag = `PC[XLEN-1:log2(BTB_ENTRIES)+2]`; each entry holds a valid bit, the tag and the target.
  - Hit = entry valid and tag equal.
- BTB update:
  - When `ex_branch && ex_taken`, write the entry at `ex_PC`'s index with valid=1, `ex_PC`'s tag and `ex_target`.
  - A not-taken resolution never invalidates an entry.
  - The write takes effect at the clock edge.
- Prediction: `fetch_pred_taken = fetch_valid && btb_hit && predict_taken`. When it is 1, `fetch_pred_target` = BTB target.
- FSM states:
  - BOOT (state on reset): `fetch_valid` = 0, PC = `RESET_PC`. Goes to RUN next cycle.
  - RUN: `fetch_valid` = 1.
  - FLUSH: `fetch_valid` = 0 for one cycle, PC already holds the redirect target. Goes to RUN next cycle.
- Next-PC priority, highest first:
  1. `ex_mispredict`: PC ← (`ex_taken` ? `ex_target` : `ex_PC`+4); state ← FLUSH. Applies from any state.
  2. RUN and not transferred (`fetch_ready` = 0): PC held.
  3. RUN and transferred: PC ← `fetch_pred_taken` ? target : PC+4.
  4. BOOT or FLUSH: PC held; state ← RUN.
- PC+4 is computed modulo 2^`XLEN`, so it wraps at the top of the address space.

## Timing
- Reset, asserted asynchronously: PC = `RESET_PC`, `fetch_valid` = 0, `fetch_pred_taken` = 0, `fetch_pred_target` = 0, state = BOOT, all BTB valid bits = 0.
- First valid fetch is the second rising edge after reset deasserts.
- Next-PC selection is combinational from `PC`, `predict_taken` and the BTB. The predicted target is fetched the cycle after the branch transfers, with zero bubbles.
- Mispredict penalty is one bubble cycle (FLUSH) before the redirect target is valid.
- Stall: `fetch_valid` is not dropped and PC is stable while `fetch_ready` = 0.
- Simultaneous events:
  - Mispredict during a stall: the mispredict wins, and the stalled fetch is discarded.
  - Mispredict during FLUSH: retarget and remain in FLUSH one more cycle.
  - BTB write to the same index being looked up: the lookup sees the old contents.
- Reset asserted mid-FLUSH or mid-stall returns the block immediately to the reset values.

## Configuration
- `FETCH_BTB_EN` defined: BTB instantiated; taken predictions redirect fetch as described.
- `FETCH_BTB_EN` undefined:
  - No BTB storage.
  - `fetch_pred_taken` = 0 and `fetch_pred_target` = 0.
  - Next PC is always PC+4 except on mispredict redirects; `predict_taken` is ignored.

## Test plan
Defaults: `BTB_ENTRIES`=16, `RESET_PC`=0, `FETCH_BTB_EN` defined.
- Reset and boot: hold `reset`=0 → PC=0, `fetch_valid`=0. Release with `fetch_ready`=1 → one cycle `fetch_valid`=0, then PC=0x0, 0x4, 0x8 with `fetch_valid`=1.
- Stall: `fetch_ready`=0 for 3 cycles at PC=0x8 → PC stays 0x8 and `fetch_valid` stays 1. Set `fetch_ready`=1 → next PC=0xC.
- BTB train and hit: `ex_branch`=1, `ex_taken`=1, `ex_PC`=0x10, `ex_target`=0x40, `ex_mispredict`=0, then fetch reaches 0x10.
  - With `predict_taken`=1 → `fetch_pred_taken`=1, `fetch_pred_target`=0x40, next PC=0x40.
  - With `predict_taken`=0 → next PC=0x14.
- Alias miss: train `ex_PC`=0x50 → 0x80 (same index 4 as 0x10, different tag), then fetch 0x10 with `predict_taken`=1 → `fetch_pred_taken`=0, next PC=0x14.
- Mispredict: `ex_mispredict`=1, `ex_taken`=0, `ex_PC`=0x10 while stalled at 0x44 → next cycle `fetch_valid`=0, PC=0x14; the cycle after, `fetch_valid`=1, PC=0x14.
- Reset mid-FLUSH: assert `reset`=0 during the bubble → PC=0 and `fetch_valid`=0 immediately, and no BTB hit on 0x10 after release.
